rca_multiword_seq: RTL and testbench
====================================

# rca_multiword_seq

Multi-cycle sequencer that reuses a single `ripple_carry_adder_4bit` instance to add WIDTH-bit operands one 4-bit slice per cycle, LSB slice first. The slice carry is registered between cycles. Requests and responses use valid/ready handshakes. It sits between a requester (for example a bus-attached accumulator) and the 4-bit adder datapath, trading latency for area.

## Interface
- WIDTH, 16, operand/sum width; multiple of 4 and ≥4; NSLICE = WIDTH/4.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  synchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request; high only in IDLE.
- a_i  input  WIDTH  operand A; sampled only at request handshake.
- b_i  input  WIDTH  operand B; sampled only at request handshake.
- cin_i  input  1  carry in; sampled only at request handshake.
- rsp_valid_o  output  1  result available; high only in DONE.
- rsp_ready_i  input  1  consumer accepts result.
- sum_o  output  WIDTH  registered sum.
- cout_o  output  1  registered unsigned carry out of the MSB.
- ovf_o  output  1  registered signed overflow (two's complement).
- busy_o  output  1  high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: req_ready_o=1. On req_valid_i&&req_ready_o:
    - latch a_i, b_i into operand registers; latch cin_i into the carry register.
    - clear sum register, set slice index idx=0, go to RUN.
  - RUN: the adder sees a[4·idx+3:4·idx], b[4·idx+3:4·idx] and the carry register. Each cycle:
    - write the adder sum into sum[4·idx+3:4·idx].
    - carry register ← adder cout.
    - if idx==NSLICE-1: go to DONE, register cout_o and ovf_o; else idx+1.
  - DONE: rsp_valid_o=1. On rsp_ready_i: go to IDLE. rsp_valid_o drops the next cycle.
- ovf_o = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1). Carry into MSB = a[W-1]^b[W-1]^sum[W-1].
- Arithmetic is modulo 2^WIDTH; result = a + b + cin.
- Input changes outside the request handshake have no effect. req_valid_i is ignored in RUN and DONE.
- sum_o, cout_o and ovf_o hold stable from DONE entry until the response handshake, and remain at the last values in IDLE.
- idx width = max(1, clog2(NSLICE)). With WIDTH=4, RUN lasts exactly 1 cycle.
- No overlap: a new request is accepted only after returning to IDLE.

## Timing
- Reset (rst_n_i low at an edge): state IDLE, idx 0, carry 0.
- Output values after reset: req_ready_o=1, rsp_valid_o=0, busy_o=0, sum_o=0, cout_o=0, ovf_o=0.
- Reset mid-RUN or in DONE: the operation is abandoned, no response is issued, and the state is IDLE on the next cycle.
- Latency: request handshake at edge E0; slices complete at edges E1..E(NSLICE); rsp_valid_o is high in the cycle after E(NSLICE).
  - For WIDTH=16, rsp_valid_o is high 4 cycles after acceptance.
- Throughput: min NSLICE+2 cycles per operation, covering RUN, one DONE cycle with rsp_ready_i high, and IDLE accept.
- rsp_valid_o stays high indefinitely while rsp_ready_i is low. No combinational path from rsp_ready_i or req_valid_i to any output.
- busy_o rises the cycle after acceptance and falls the cycle after the response handshake.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0: sum_o=0x5555, cout_o=0, ovf_o=0; rsp_valid_o high exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0: sum_o=0x0000, cout_o=1, ovf_o=0. Proves the carry propagates through all 4 slices.
- a=0x7FFF, b=0x0001, cin=0: sum_o=0x8000, cout_o=0, ovf_o=1. Then a=0x000F, b=0x0000, cin=1: sum_o=0x0010, cout_o=0, ovf_o=0.
- Backpressure: hold rsp_ready_i=0 for 5 cycles in DONE while toggling req_valid_i and a_i:
  - sum_o, cout_o, ovf_o stay stable; req_ready_o=0; nothing new is accepted.
  - Raising rsp_ready_i returns the block to IDLE next cycle.
- Reset mid-operation: assert rst_n_i=0 for one edge during slice 2 of RUN.
  - Next cycle: rsp_valid_o=0, busy_o=0, all outputs 0, and no stale response appears.
  - A following 0x0001+0x0001 returns 0x0002.
- Back-to-back: 20 random operand/cin triples with random rsp_ready_i stalls. Each response matches a+b+cin mod 2^16, with correct cout_o and ovf_o, in order, with no lost or duplicated results.

Source files
------------

// File: rtl/rca_multiword_seq.sv
// -----------------------------------------------------------------------------
// rca_multiword_seq
//
// Purpose:
//   Adds two WIDTH-bit operands plus a carry-in using a single 4-bit ripple
//   carry adder. One 4-bit slice is processed per clock, LSB slice first, and
//   the slice carry is held in a register between cycles. Requests and
//   responses use valid/ready handshakes. No new request is accepted until
//   the previous response has been taken.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_n_i      in   synchronous active-low reset
//   req_valid_i  in   request present
//   req_ready_o  out  block idle and able to accept a request
//   a_i, b_i     in   WIDTH-bit operands, sampled at request handshake
//   cin_i        in   carry in, sampled at request handshake
//   rsp_valid_o  out  result available
//   rsp_ready_i  in   consumer accepts result
//   sum_o        out  WIDTH-bit sum (a + b + cin mod 2^WIDTH)
//   cout_o       out  unsigned carry out of the MSB
//   ovf_o        out  two's complement overflow
//   busy_o       out  high whenever the block is not idle
// -----------------------------------------------------------------------------

// 4-bit ripple carry adder used as the shared slice datapath.
module ripple_carry_adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [4:0] c_s;

    assign c_s[0] = cin_i;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum_o[i]  = a_i[i] ^ b_i[i] ^ c_s[i];
        assign c_s[i+1]  = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c_s[4];
endmodule

module rca_multiword_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;

    logic [3:0]         slice_a_s;
    logic [3:0]         slice_b_s;
    logic [3:0]         slice_sum_s;
    logic               slice_cout_s;
    logic               msb_cin_s;

    // Select the operand slice addressed by the current index.
    assign slice_a_s = a_q[{idx_q, 2'b00} +: 4];
    assign slice_b_s = b_q[{idx_q, 2'b00} +: 4];

    ripple_carry_adder_4bit u_adder (
        .a_i    (slice_a_s),
        .b_i    (slice_b_s),
        .cin_i  (carry_q),
        .sum_o  (slice_sum_s),
        .cout_o (slice_cout_s)
    );

    // Carry into the MSB is recovered from the MSB sum bit of the last slice,
    // so no internal carry of the adder has to be exposed.
    assign msb_cin_s = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum_s[3];

    // Next-state and datapath update for the slice sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = slice_sum_s;
                carry_d                    = slice_cout_s;
                if (idx_q == IDX_LAST) begin
                    cout_d  = slice_cout_s;
                    ovf_d   = msb_cin_s ^ slice_cout_s;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode the state register only, so no input reaches
    // an output combinationally.
    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_rca_multiword_seq.sv
// -----------------------------------------------------------------------------
// tb_rca_multiword_seq
//
// Self-checking bench for rca_multiword_seq (WIDTH=16). Stimulus pushes the
// expected response of every accepted request into a queue; a monitor on the
// falling edge pops and compares whenever a response handshake is seen.
// -----------------------------------------------------------------------------
module tb_rca_multiword_seq;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } rsp_t;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         ovf_o;
    logic         busy_o;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_rsp    = 0;

    rca_multiword_seq #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .cin_i       (cin_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .sum_o       (sum_o),
        .cout_o      (cout_o),
        .ovf_o       (ovf_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request and hold it until the handshake edge; optionally
    // push the expected response.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec, input logic eo, input bit push);
        int cnt;
        req_valid_i = 1'b1;
        a_i = a;
        b_i = b;
        cin_i = c;
        cnt = 0;
        while (!req_ready_o && cnt < 100) begin
            tick();
            cnt++;
        end
        if (cnt >= 100) begin
            timeout_fail("send");
        end
        tick();
        req_valid_i = 1'b0;
        if (push) begin
            exp_q.push_back('{sum: es, cout: ec, ovf: eo});
        end
    endtask

    // Drive rsp_ready_i (constant 1 or random) until the response is taken.
    task automatic finish_rsp(input bit rnd);
        int cnt;
        bit done;
        cnt = 0;
        done = 1'b0;
        while (!done && cnt < 200) begin
            rsp_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            done = rsp_valid_o && rsp_ready_i;
            tick();
            cnt++;
        end
        rsp_ready_i = 1'b0;
        if (!done) begin
            timeout_fail("finish_rsp");
        end
    endtask

    // Scoreboard monitor: compare each response handshake with the queue head.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk_i);
            if (rsp_valid_o && rsp_ready_i) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    timeout_fail("unexpected_rsp");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_sum", sum_o, e.sum);
                    check("rsp_cout", cout_o, e.cout);
                    check("rsp_ovf", ovf_o, e.ovf);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   full;
        logic         rovf;

        rst_n_i     = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        a_i         = '0;
        b_i         = '0;
        cin_i       = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;

        // Reset state
        check("rst_req_ready", req_ready_o, 1'b1);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_sum", sum_o, 16'h0000);
        check("rst_cout", cout_o, 1'b0);
        check("rst_ovf", ovf_o, 1'b0);

        // Basic add with latency check: valid exactly 4 cycles after accept
        send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
        check("busy_after_accept", busy_o, 1'b1);
        check("req_ready_in_run", req_ready_o, 1'b0);
        tick();
        tick();
        tick();
        check("lat_valid_early", rsp_valid_o, 1'b0);
        tick();
        check("lat_valid_on_time", rsp_valid_o, 1'b1);
        finish_rsp(1'b0);
        check("busy_after_rsp", busy_o, 1'b0);

        // Full carry ripple, signed overflow, carry-in
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        finish_rsp(1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        finish_rsp(1'b0);
        send(16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b1);
        finish_rsp(1'b0);

        // Backpressure: hold DONE for 5 cycles while toggling request inputs
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            req_valid_i = ~req_valid_i;
            a_i = a_i ^ 16'h5A5A;
            tick();
            check("bp_rsp_valid", rsp_valid_o, 1'b1);
            check("bp_req_ready", req_ready_o, 1'b0);
            check("bp_sum", sum_o, 16'h0000);
            check("bp_cout", cout_o, 1'b1);
            check("bp_ovf", ovf_o, 1'b1);
        end
        req_valid_i = 1'b0;
        finish_rsp(1'b0);
        check("bp_idle_ready", req_ready_o, 1'b1);
        check("bp_idle_valid", rsp_valid_o, 1'b0);
        check("bp_idle_hold_cout", cout_o, 1'b1);
        check("bp_idle_hold_ovf", ovf_o, 1'b1);

        // Reset during slice 2 of RUN: operation abandoned, nothing returned
        send(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        check("mid_rst_valid", rsp_valid_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_sum", sum_o, 16'h0000);
        check("mid_rst_cout", cout_o, 1'b0);
        check("mid_rst_ovf", ovf_o, 1'b0);
        check("mid_rst_ready", req_ready_o, 1'b1);
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check("mid_rst_no_stale", busy_o, 1'b0);
        rsp_ready_i = 1'b0;
        send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
        finish_rsp(1'b0);

        // Back-to-back random operations with random response stalls
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            rovf = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
            send(ra, rb, rc, full[W-1:0], full[W], rovf, 1'b1);
            finish_rsp(1'b1);
        end

        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        check("rsp_count", n_rsp, 26);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
